// File: rtl/core_mc_seq.sv
// Multi-cycle FETCH/EXEC/MEM sequencer for the RV32 core. It owns PC and IR and talks
// req/ready to both memories; decode, ALU and register file consume pc/ir/commit outside.
`timescale 1ns/1ps
module core_mc_seq #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              TIMEOUT  = 0,
  parameter int              CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             stop,
  output logic             imem_req,
  output logic [XLEN-1:0]  imem_addr,
  input  logic             imem_ready,
  input  logic [31:0]      imem_rdata,
  input  logic             mem_op,
  input  logic [XLEN-1:0]  nextpc,
  output logic             dmem_req,
  input  logic             dmem_ready,
  output logic [XLEN-1:0]  pc,
  output logic [31:0]      ir,
  output logic             commit,
  output logic             active,
  output logic             error,
  output logic [CNT_W-1:0] retire_cnt
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_MEM   = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // One spare bit so the counter can always represent TIMEOUT itself.
  localparam int              WAIT_W = $clog2(TIMEOUT + 1) + 1;
  localparam logic [WAIT_W-1:0] TO_V  = WAIT_W'(TIMEOUT);
  localparam bit              TO_EN  = (TIMEOUT > 0);

  logic [2:0]       state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [31:0]      ir_q, ir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  logic             commit_c;
  logic             misalign;
  logic             timed_out;
  logic [WAIT_W-1:0] wait_inc;

  assign misalign  = |nextpc[1:0];
  assign timed_out = TO_EN && (wait_q == TO_V);
  // Saturate so a disabled timeout never wraps back into a spurious match.
  assign wait_inc  = (&wait_q) ? wait_q : wait_q + 1'b1;

  assign commit_c = ((state_q == S_EXEC) && !mem_op) ||
                    ((state_q == S_MEM)  && dmem_ready);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    wait_d  = wait_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          wait_d  = '0;
        end
      end
      S_FETCH: begin
        if (imem_ready) begin
          ir_d    = imem_rdata;
          state_d = S_EXEC;
        end else if (timed_out) begin
          err_d   = 1'b1;
          state_d = S_ERR;
        end else begin
          wait_d  = wait_inc;
        end
      end
      S_EXEC: begin
        if (mem_op) begin
          state_d = S_MEM;
          wait_d  = '0;
        end
      end
      S_MEM: begin
        if (!dmem_ready) begin
          if (timed_out) begin
            err_d   = 1'b1;
            state_d = S_ERR;
          end else begin
            wait_d  = wait_inc;
          end
        end
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        err_d   = 1'b1;
        state_d = S_ERR;
      end
    endcase

    // A misaligned target still retires; the fault is raised afterwards.
    if (commit_c) begin
      pc_d   = nextpc;
      cnt_d  = cnt_q + 1'b1;
      wait_d = '0;
      if (misalign) begin
        err_d   = 1'b1;
        state_d = S_ERR;
      end else begin
        state_d = stop ? S_IDLE : S_FETCH;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= NOP;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      wait_q  <= wait_d;
    end
  end

  assign imem_req   = (state_q == S_FETCH);
  assign imem_addr  = pc_q;
  assign dmem_req   = (state_q == S_MEM);
  assign active     = (state_q == S_FETCH) || (state_q == S_EXEC) || (state_q == S_MEM);
  assign commit     = commit_c;
  assign pc         = pc_q;
  assign ir         = ir_q;
  assign error      = err_q;
  assign retire_cnt = cnt_q;

endmodule

// File: tb/tb_core_mc_seq.sv
// Bench for core_mc_seq: memory/control responders, a per-cycle behavioural reference
// and directed scenarios with hand-computed end-state expectations.
`timescale 1ns/1ps
module tb_core_mc_seq;
  localparam int          TO  = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int P_IDLE = 0, P_FETCH = 1, P_EXEC = 2, P_MEM = 3, P_ERR = 4;

  logic        clk = 1'b0, rstn = 1'b0, start = 1'b0, stop = 1'b0;
  logic        imem_ready = 1'b0, mem_op = 1'b0, dmem_ready = 1'b0;
  logic [31:0] imem_rdata = '0, nextpc = '0;
  logic        imem_req, dmem_req, commit, active, error;
  logic [31:0] imem_addr, pc, ir;
  logic [3:0]  retire_cnt;

  int checks = 0, failures = 0;
  int idelay = 0, ddelay = 0, n;
  logic        force_en = 1'b0;
  logic [31:0] force_np = '0;
  logic [31:0] prog [64];

  core_mc_seq #(.XLEN(32), .RESET_PC(32'h0), .TIMEOUT(TO), .CNT_W(4)) dut (
    .clk(clk), .rstn(rstn), .start(start), .stop(stop),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .mem_op(mem_op), .nextpc(nextpc),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .pc(pc), .ir(ir),
    .commit(commit), .active(active), .error(error), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  // Memories answer after a programmable number of request cycles; control decodes ir.
  initial begin : env
    int ik, dk;
    ik = 0; dk = 0;
    forever begin
      @(posedge clk); #1;
      if (imem_req) begin
        imem_ready = (ik == idelay);
        imem_rdata = imem_ready ? prog[imem_addr[7:2]] : 32'hBAD0_BAD0;
        ik++;
      end else begin
        imem_ready = 1'b0;
        imem_rdata = 32'hBAD0_BAD0;
        ik = 0;
      end
      if (dmem_req) begin
        dmem_ready = (dk == ddelay);
        dk++;
      end else begin
        dmem_ready = 1'b0;
        dk = 0;
      end
      mem_op = (ir[6:0] == 7'h03) || (ir[6:0] == 7'h23);
      nextpc = force_en ? force_np : pc + 32'd4;
    end
  end

  // Reference: what each phase must show, then how the phase moves on at the edge.
  initial begin : model
    int ph, waited, m_cnt;
    logic [31:0] m_pc, m_ir;
    logic m_err, e_commit;
    ph = P_IDLE; waited = 0; m_cnt = 0; m_pc = 0; m_ir = NOP; m_err = 0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        ph = P_IDLE; waited = 0; m_cnt = 0; m_pc = 0; m_ir = NOP; m_err = 0;
      end
      e_commit = rstn && (((ph == P_EXEC) && !mem_op) || ((ph == P_MEM) && dmem_ready));
      chk("m_imem_req", {31'b0, imem_req}, {31'b0, ph == P_FETCH});
      chk("m_imem_addr", imem_addr, m_pc);
      chk("m_dmem_req", {31'b0, dmem_req}, {31'b0, ph == P_MEM});
      chk("m_active", {31'b0, active}, {31'b0, ph == P_FETCH || ph == P_EXEC || ph == P_MEM});
      chk("m_commit", {31'b0, commit}, {31'b0, e_commit});
      chk("m_pc", pc, m_pc);
      chk("m_ir", ir, m_ir);
      chk("m_error", {31'b0, error}, {31'b0, m_err});
      chk("m_retire", {28'b0, retire_cnt}, 32'(m_cnt));
      if (rstn) begin
        case (ph)
          P_IDLE:  if (start) begin ph = P_FETCH; waited = 0; end
          P_FETCH: if (imem_ready) begin m_ir = imem_rdata; ph = P_EXEC; end
                   else if (waited == TO) begin m_err = 1; ph = P_ERR; end
                   else waited++;
          P_EXEC:  if (mem_op) begin ph = P_MEM; waited = 0; end
          P_MEM:   if (!dmem_ready) begin
                     if (waited == TO) begin m_err = 1; ph = P_ERR; end
                     else waited++;
                   end
          default: ;
        endcase
        if (e_commit) begin
          m_pc = nextpc;
          m_cnt = (m_cnt + 1) % 16;
          waited = 0;
          if (nextpc[1:0] != 2'b00) begin m_err = 1; ph = P_ERR; end
          else ph = stop ? P_IDLE : P_FETCH;
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    for (int i = 0; i < 64; i++) prog[i] = 32'h0000_0093 | (32'(i) << 20);
    prog[12] = 32'h0000_a103;  // lw
    prog[17] = 32'h0020_a023;  // sw

    rstn = 1'b0;
    tick(2);
    chk("rst_pc", pc, 32'h0);
    chk("rst_ir", ir, NOP);
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    rstn = 1'b1;
    tick(1);

    // ADDI stream, zero-wait fetch: 20 cycles -> 10 retirements
    pulse_start();
    tick(20);
    chk("stream_retire", {28'b0, retire_cnt}, 32'd10);
    chk("stream_pc", pc, 32'h28);
    chk("stream_req", {31'b0, imem_req}, 32'h1);

    stop = 1'b1;
    tick(4);
    chk("stop_pc", pc, 32'h2C);
    chk("stop_idle", {31'b0, imem_req | active}, 32'h0);

    // fetch with 3 wait states; start and stop together
    idelay = 3;
    pulse_start();
    tick(8);
    chk("iwait_pc", pc, 32'h30);
    chk("iwait_ir", ir, 32'h00b0_0093);
    chk("iwait_retire", {28'b0, retire_cnt}, 32'd12);

    // load with 2 data wait states
    idelay = 0; ddelay = 2;
    pulse_start();
    tick(8);
    chk("mem_pc", pc, 32'h34);
    chk("mem_ir", ir, 32'h0000_a103);
    chk("mem_retire", {28'b0, retire_cnt}, 32'd13);

    // fetch timeout
    idelay = 100; stop = 1'b0;
    pulse_start();
    tick(8);
    chk("to_error", {31'b0, error}, 32'h1);
    chk("to_req", {31'b0, imem_req}, 32'h0);
    chk("to_pc", pc, 32'h34);
    pulse_start();
    tick(2);
    chk("to_sticky", {31'b0, error & ~active}, 32'h1);
    rstn = 1'b0; tick(1); rstn = 1'b1; tick(1);
    chk("to_rst_err", {31'b0, error}, 32'h0);

    // ready arriving when the counter reaches TIMEOUT wins
    idelay = 4; stop = 1'b1;
    pulse_start();
    tick(10);
    chk("edge_error", {31'b0, error}, 32'h0);
    chk("edge_pc", pc, 32'h4);
    chk("edge_retire", {28'b0, retire_cnt}, 32'd1);

    // misaligned target
    idelay = 0; stop = 1'b0; force_en = 1'b1; force_np = 32'h102;
    pulse_start();
    tick(4);
    chk("mis_pc", pc, 32'h102);
    chk("mis_error", {31'b0, error}, 32'h1);
    chk("mis_active", {31'b0, active}, 32'h0);
    chk("mis_retire", {28'b0, retire_cnt}, 32'd2);
    force_en = 1'b0;
    pulse_start();
    tick(3);
    chk("mis_start_ign", {31'b0, imem_req | active}, 32'h0);
    rstn = 1'b0; tick(1); rstn = 1'b1; tick(1);
    chk("mis_rst_pc", pc, 32'h0);
    chk("mis_rst_err", {31'b0, error}, 32'h0);

    // 17 commits on a 4-bit counter
    pulse_start();
    n = 0;
    for (int c = 0; c < 400 && n < 17; c++) begin
      @(posedge clk); #2;
      if (commit) begin
        n++;
        if (n == 17) stop = 1'b1;
      end
    end
    chk("wrap_commits", 32'(n), 32'd17);
    tick(4);
    chk("wrap_retire", {28'b0, retire_cnt}, 32'd1);
    chk("wrap_pc", pc, 32'h44);

    // reset in the middle of a store
    stop = 1'b0; ddelay = 3;
    pulse_start();
    tick(2);
    chk("mid_dreq", {31'b0, dmem_req}, 32'h1);
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_dreq", {31'b0, dmem_req}, 32'h0);
    chk("mid_rst_pc", pc, 32'h0);
    chk("mid_rst_ir", ir, NOP);
    chk("mid_rst_retire", {28'b0, retire_cnt}, 32'd0);
    chk("mid_rst_act", {31'b0, active | commit | imem_req}, 32'h0);
    tick(1);
    rstn = 1'b1;
    tick(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
